seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
- Consumer end of the switch-capture interface: takes single-cycle `valid`/`data[7:0]` pulses from the button/switch capture block.
- Holds the last four captured bytes in a shift buffer.
- Displays them as hex on the board's 8-digit common-anode seven-segment display using time-multiplexed scanning.
- Sits between the input capture block and the top-level display pins.

Parameters:
- SCAN_DIV, 20000, clk cycles per digit slot (100 MHz -> 200 us/digit); must be >= 2.
- DIV_W, 15, width of the scan divider counter; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- valid  in  1  one-cycle strobe; data is captured on this cycle
- data  in  8  byte to display; sampled only when valid=1
- clear  in  1  synchronous buffer clear, level-sensitive
- led_en  out  8  digit enables, active-low, one-hot-low; bit i = digit i, digit 0 rightmost
- seg  out  8  segments, active-low; seg[0]=a … seg[6]=g, seg[7]=dp
- count  out  3  number of valid bytes held, 0..4

Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.

Behaviour:
- Reset (async, rst=1):
  - Buffer bytes b0..b3 = 0.
  - count = 0, divider = 0, digit index = 0.
  - led_en = 8'hFF, seg = 8'hFF (all dark).
- Capture, on valid=1 at a clk edge:
  - b3<=b2, b2<=b1, b1<=b0, b0<=data.
  - count <= min(count+1, 4).
  - Saturation at 4: the oldest byte is discarded, count stays 4.
  - Back-to-back valid pulses are each captured; no cycles are lost.
- Clear (clear=1):
  - b0..b3 <= 0, count <= 0.
  - If valid=1 in the same cycle: b0 <= data, the rest 0, count <= 1. The write wins over the clear for that byte only.
- Digit mapping:
  - Digits {1,0} = b0 {hi,lo} nibble; digits {3,2} = b1; {5,4} = b2; {7,6} = b3.
  - Byte bk is blanked (seg = 8'hFF on both of its digits) when k >= count.
- Scan:
  - Divider counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap cycle, digit index <= (index+1) mod 8; 7 wraps to 0.
  - Each digit is active for exactly SCAN_DIV cycles; the full frame is 8*SCAN_DIV cycles.
- Output timing:
  - led_en and seg are registered.
  - They reflect the digit index and buffer contents of the previous cycle, i.e. 1-cycle latency.
  - led_en = ~(8'b1 << index).
  - seg is the hex pattern of the selected nibble, or 8'hFF if blanked.
- Decimal point: dp is always off (seg[7]=1).
- Hex patterns, active-low {dp,g..a}:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Ghosting: led_en and seg change on the same edge; no extra blanking slot is required.
- Mid-operation reset: outputs go dark immediately (asynchronous), and scanning restarts at digit 0 after deassertion.
- count is combinationally driven from its register, with no extra latency.

Decomposition:
- Shared package `seg_pkg`:
  - 16-entry hex-to-segment constant table (values above).
  - SEG_BLANK = 8'hFF.
  - Digit count constant NUM_DIGITS = 8.
- Sub-module `hex_to_seg7`: purely combinational 4-bit nibble -> 8-bit active-low pattern, instantiated once on the selected nibble.
- Buffer, divider and scan index stay in the top module.

Test Plan (SCAN_DIV=4 for simulation):
- Reset, then run 40 cycles with no valid -> led_en cycles FE,FD,…,7F every 4 cycles; seg stays FF; count=0.
- valid with data=8'hA5 -> count=1; during digit 0, seg=92 ('5'); during digit 1, seg=88 ('A'); digits 2-7 seg=FF.
- Five pulses 8'h01,8'h02,8'h03,8'h04,8'h3F, back-to-back cycles -> count=4 after the 4th and stays 4.
  - Digits {7,6}=02, {5,4}=03, {3,2}=04, {1,0}=3F; digit 0 seg=8E, digit 1 seg=B0.
- Buffer full, then clear=1 and valid=1 with data=8'hF0 in the same cycle -> count=1; digit0 seg=C0, digit1 seg=8E, others FF.
- rst asserted mid-frame at digit index 5 -> led_en=FF and seg=FF with no clock edge. After release, the first active slot is digit 0 (led_en=FE) and count=0.
- Divider wrap: verify every led_en value persists exactly 4 cycles, and that index 7 -> 0 occurs with no skipped or duplicated digit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment display controller.
package seg_pkg;

    // Number of physical digits on the display.
    localparam int unsigned NUM_DIGITS = 8;

    // Number of captured bytes held for display (two digits per byte).
    localparam int unsigned NUM_BYTES = 4;

    // Saturation value of the byte counter.
    localparam logic [2:0] COUNT_MAX = 3'd4;

    // All segments off, decimal point off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Hex digit to segment pattern, active-low {dp, g, f, e, d, c, b, a}.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Active-low one-hot digit enable for a digit index.
    function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [2:0] idx);
        logic [NUM_DIGITS-1:0] one;
        one = NUM_DIGITS'(1);
        return ~(one << idx);
    endfunction

    // Byte count after one capture, saturating at COUNT_MAX.
    function automatic logic [2:0] count_after_capture(input logic [2:0] cnt);
        return (cnt >= COUNT_MAX) ? COUNT_MAX : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    // Table lookup; decimal point is always off in the table values.
    always_comb begin
        pattern = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-byte capture buffer shown as hex on an 8-digit multiplexed
// common-anode seven-segment display.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 20000,
    parameter int unsigned DIV_W    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic       clear,
    output logic [7:0] led_en,
    output logic [7:0] seg,
    output logic [2:0] count
);

    // Reject parameter sets the divider cannot represent.
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("seg_display_ctrl: SCAN_DIV must be >= 2");
    end
    if ((64'd1 << DIV_W) < 64'(SCAN_DIV)) begin : g_bad_width
        $error("seg_display_ctrl: DIV_W too narrow for SCAN_DIV");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [7:0]       buf_q [NUM_BYTES];
    logic [2:0]       count_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;

    logic [1:0]       byte_sel;
    logic [3:0]       nibble;
    logic             blank;
    logic [7:0]       hex_pat;

    // Capture shift buffer with saturating count; clear zeroes all bytes
    // but a simultaneous capture still lands in b0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                buf_q[i] <= '0;
            end
            count_q <= '0;
        end else if (clear) begin
            for (int unsigned i = 1; i < NUM_BYTES; i++) begin
                buf_q[i] <= '0;
            end
            buf_q[0] <= valid ? data : '0;
            count_q  <= valid ? 3'd1 : 3'd0;
        end else if (valid) begin
            for (int unsigned i = 1; i < NUM_BYTES; i++) begin
                buf_q[i] <= buf_q[i-1];
            end
            buf_q[0] <= data;
            count_q  <= count_after_capture(count_q);
        end
    end

    // Scan divider; the digit index advances on the divider wrap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 3'd1;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Select the nibble for the current digit and decide if its byte is empty.
    always_comb begin
        byte_sel = idx_q[2:1];
        nibble   = idx_q[0] ? buf_q[byte_sel][7:4] : buf_q[byte_sel][3:0];
        blank    = ({1'b0, byte_sel} >= count_q);
    end

    hex_to_seg7 u_hex (
        .nibble  (nibble),
        .pattern (hex_pat)
    );

    // Registered display drive; enable and segments switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en <= '1;
            seg    <= SEG_BLANK;
        end else begin
            led_en <= digit_enable(idx_q);
            seg    <= blank ? SEG_BLANK : hex_pat;
        end
    end

    // Byte count is visible straight from its register.
    always_comb begin
        count = count_q;
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a short scan divider.
module tb_seg_display_ctrl;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       clear;
    logic [7:0] led_en;
    logic [7:0] seg;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    logic [7:0] seg_at [8];
    logic       seen   [8];

    seg_display_ctrl #(
        .SCAN_DIV (SD),
        .DIV_W    (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .data   (data),
        .clear  (clear),
        .led_en (led_en),
        .seg    (seg),
        .count  (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One-cycle strobe issued from a negedge; returns at the following negedge.
    task automatic pulse(input logic v, input logic c, input logic [7:0] d);
        valid = v;
        clear = c;
        data  = d;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        clear = 1'b0;
    endtask

    // Watch a bit more than one frame and record seg seen under each digit.
    task automatic grab_frame();
        logic [7:0] one;
        for (int d = 0; d < 8; d++) begin
            seen[d]   = 1'b0;
            seg_at[d] = 8'h00;
        end
        for (int k = 0; k < 8*SD + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                one = 8'b1 << d;
                if (led_en == ~one) begin
                    seen[d]   = 1'b1;
                    seg_at[d] = seg;
                end
            end
        end
    endtask

    // Expected patterns packed {d7, ..., d0}.
    task automatic check_frame(input string tag, input logic [63:0] e);
        grab_frame();
        for (int d = 0; d < 8; d++) begin
            check($sformatf("%s_seen_d%0d", tag, d), {7'b0, seen[d]}, 8'd1);
            check($sformatf("%s_seg_d%0d", tag, d), seg_at[d], e[8*d +: 8]);
        end
    endtask

    initial begin
        logic [7:0] one;
        logic [7:0] exp_led;
        logic       found;

        rst   = 1'b1;
        valid = 1'b0;
        clear = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_led", led_en, 8'hFF);
        check("rst_seg", seg, 8'hFF);
        check("rst_cnt", {5'b0, count}, 8'd0);

        // Idle scan: each digit held SD cycles, 7 wraps to 0.
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            one     = 8'b1 << (((k - 1) / SD) % 8);
            exp_led = ~one;
            check($sformatf("idle_led_%0d", k), led_en, exp_led);
            check($sformatf("idle_seg_%0d", k), seg, 8'hFF);
            check($sformatf("idle_cnt_%0d", k), {5'b0, count}, 8'd0);
        end

        // Single byte A5.
        pulse(1'b1, 1'b0, 8'hA5);
        check("a5_cnt", {5'b0, count}, 8'd1);
        check_frame("a5", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'h92});

        // Clear, then five back-to-back captures with saturation.
        pulse(1'b0, 1'b1, 8'h00);
        check("clr_cnt", {5'b0, count}, 8'd0);
        pulse(1'b1, 1'b0, 8'h01);
        check("bb_cnt1", {5'b0, count}, 8'd1);
        pulse(1'b1, 1'b0, 8'h02);
        check("bb_cnt2", {5'b0, count}, 8'd2);
        pulse(1'b1, 1'b0, 8'h03);
        check("bb_cnt3", {5'b0, count}, 8'd3);
        pulse(1'b1, 1'b0, 8'h04);
        check("bb_cnt4", {5'b0, count}, 8'd4);
        pulse(1'b1, 1'b0, 8'h3F);
        check("bb_cnt5", {5'b0, count}, 8'd4);
        check_frame("full", {8'hC0, 8'hA4, 8'hC0, 8'hB0, 8'hC0, 8'h99, 8'hB0, 8'h8E});

        // Clear and capture together: only the new byte survives.
        pulse(1'b1, 1'b1, 8'hF0);
        check("clrw_cnt", {5'b0, count}, 8'd1);
        check_frame("clrw", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h8E, 8'hC0});

        // Asynchronous reset while digit 5 is lit.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (led_en == 8'hDF) found = 1'b1;
        end
        check("find_d5", {7'b0, found}, 8'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_led", led_en, 8'hFF);
        check("arst_seg", seg, 8'hFF);
        check("arst_cnt", {5'b0, count}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 2*SD; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_led = (k <= SD) ? 8'hFE : 8'hFD;
            check($sformatf("post_led_%0d", k), led_en, exp_led);
            check($sformatf("post_seg_%0d", k), seg, 8'hFF);
            check($sformatf("post_cnt_%0d", k), {5'b0, count}, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
